// File: rtl/freq_err_pkg.sv
// Shared FSM encoding and symmetric saturation limit for the frequency error detector.
package freq_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_CLIP  = 2'd2
  } state_t;

  // Largest magnitude representable symmetrically in a w-bit signed word.
  function automatic longint sym_lim(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

endpackage

// File: rtl/sat_shl.sv
// Arithmetic left shift by a runtime amount, saturated to the symmetric limit.
module sat_shl
  import freq_err_pkg::*;
#(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned GAIN_W = 2
) (
  input  logic signed [WIDTH-1:0]  a,
  input  logic        [GAIN_W-1:0] sh,
  output logic signed [WIDTH-1:0]  y,
  output logic                     ovf
);

  localparam int unsigned EW = WIDTH + (1 << GAIN_W) - 1;
  localparam logic signed [EW-1:0] LIM = EW'(sym_lim(WIDTH));

  logic signed [EW-1:0] wide;

  // Extended word has enough headroom that the shift itself never wraps.
  always_comb begin
    wide = EW'(a) <<< sh;
    y    = WIDTH'(wide);
    ovf  = 1'b0;
    if (wide > LIM) begin
      y   = WIDTH'(LIM);
      ovf = 1'b1;
    end else if (wide < -LIM) begin
      y   = WIDTH'(-LIM);
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/freq_err_det.sv
// PFD-driven frequency error accumulator with event or fixed-window dump and scaled output.
module freq_err_det
  import freq_err_pkg::*;
#(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned STEP   = 1,
  parameter int unsigned GAIN_W = 2,
  parameter int unsigned WIN    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    R,
  input  logic                    V,
  input  logic                    mode,
  input  logic       [GAIN_W-1:0] gain,
  output logic                    out_en,
  output logic signed [WIDTH-1:0] out,
  output logic                    sat,
  output logic                    ovf
);

  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned CW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic signed [XW-1:0] LIM      = XW'(sym_lim(WIDTH));
  localparam logic signed [XW-1:0] STEP_X   = XW'(STEP);
  localparam logic        [CW-1:0] WIN_LAST = CW'(WIN - 1);

  state_t                   state;
  logic signed [WIDTH-1:0]  acc;
  logic        [CW-1:0]     wcnt;
  logic                     mode_q;
  logic                     sat_flag;

  logic                     mode_chg;
  logic                     mode_eff;
  logic        [CW-1:0]     wcnt_eff;
  logic signed [XW-1:0]     sum;
  logic signed [WIDTH-1:0]  acc_step;
  logic                     clamp;
  logic                     dump;
  logic signed [WIDTH-1:0]  shl_y;
  logic                     shl_ovf;

  // Mode is only adopted from IDLE; the adopting cycle is the first of a fresh window.
  always_comb begin
    mode_chg = (state == ST_IDLE) && (mode != mode_q);
    mode_eff = (state == ST_IDLE) ? mode : mode_q;
    wcnt_eff = mode_chg ? '0 : wcnt;

    sum = XW'(acc);
    if (R && !V)
      sum = XW'(acc) + STEP_X;
    else if (!R && V)
      sum = XW'(acc) - STEP_X;

    acc_step = WIDTH'(sum);
    clamp    = 1'b0;
    if (sum > LIM) begin
      acc_step = WIDTH'(LIM);
      clamp    = 1'b1;
    end else if (sum < -LIM) begin
      acc_step = WIDTH'(-LIM);
      clamp    = 1'b1;
    end

    if (mode_eff)
      dump = en && (wcnt_eff == WIN_LAST);
    else
      dump = en && (R == V) && (acc != '0);
  end

  // In event mode R==V so acc_step equals acc; in window mode it folds in the final step.
  sat_shl #(
    .WIDTH  (WIDTH),
    .GAIN_W (GAIN_W)
  ) u_sat_shl (
    .a   (acc_step),
    .sh  (gain),
    .y   (shl_y),
    .ovf (shl_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      wcnt     <= '0;
      mode_q   <= 1'b0;
      sat_flag <= 1'b0;
      out_en   <= 1'b0;
      out      <= '0;
      sat      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      out_en <= 1'b0;
      if (en) begin
        if (mode_chg)
          mode_q <= mode;
        if (dump) begin
          state    <= ST_IDLE;
          acc      <= '0;
          wcnt     <= '0;
          sat_flag <= 1'b0;
          out_en   <= 1'b1;
          out      <= shl_y;
          sat      <= sat_flag | clamp;
          ovf      <= shl_ovf;
        end else begin
          acc  <= acc_step;
          wcnt <= mode_eff ? CW'(wcnt_eff + 1'b1) : '0;
          if (clamp) begin
            sat_flag <= 1'b1;
            state    <= ST_CLIP;
          end else if (acc_step == '0) begin
            state <= ST_IDLE;
          end else if (state == ST_IDLE) begin
            state <= ST_COUNT;
          end
        end
      end
    end
  end

endmodule

// File: doc/freq_err_det.md
FREQ_ERR_DET -- requirements
Module: freq_err_det

Interface
REQ-001 SHALL have parameter WIDTH, default 24: signed accumulator and output width.
REQ-002 SHALL have parameter STEP, default 1: counter increment per imbalance cycle, 1..2^(WIDTH-2).
REQ-003 SHALL have parameter GAIN_W, default 2: width of the runtime gain-shift input.
REQ-004 SHALL have parameter WIN, default 256: dump period in enabled cycles for window mode, >=2.
REQ-005 SHALL have ports: clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: en  in  1  clock enable.
REQ-008 SHALL have ports: R  in  1  reference PFD flag.
REQ-009 SHALL have ports: V  in  1  VCO PFD flag.
REQ-010 SHALL have ports: mode  in  1  0 = event dump, 1 = window dump.
REQ-011 SHALL have ports: gain  in  GAIN_W  left-shift amount applied at dump.
REQ-012 SHALL have ports: out_en  out  1  single-cycle valid strobe.
REQ-013 SHALL have ports: out  out  WIDTH  signed, scaled frequency error.
REQ-014 SHALL have ports: sat  out  1  accumulator clipped during the dumped interval.
REQ-015 SHALL have ports: ovf  out  1  gain shift clipped on the dumped value.

Function
REQ-016 SHALL, with en high, add STEP when R&~V and subtract STEP when ~R&V; no change when R==V.
REQ-017 SHALL clamp the accumulator symmetrically to +/-(2^(WIDTH-1)-1); a clamp sets a sticky internal sat flag.
REQ-018 SHALL implement FSM IDLE (acc==0), COUNT (acc!=0, unclamped), CLIP (clamped, holding).
REQ-019 SHALL transition IDLE->COUNT on the first imbalance; COUNT->CLIP on a clamp; COUNT/CLIP->IDLE on dump.
REQ-020 SHALL, in mode 0, dump when R==V and acc!=0; nothing is emitted when R==V and acc==0.
REQ-021 SHALL, in mode 1, ignore R==V as a dump trigger and dump on every WIN-th enabled cycle, including acc==0 (out=0).
REQ-022 SHALL, in mode 1, include the current cycle's step in the dumped value when the window end coincides with imbalance; the accumulator restarts at 0.
REQ-023 SHALL register out = acc <<< gain, saturated to +/-(2^(WIDTH-1)-1), with ovf=1 when clipped; out_en pulses high for exactly 1 cycle, 1 cycle after the dump-condition cycle.
REQ-024 SHALL update sat/ovf only with out_en and clear the internal sat flag on dump.
REQ-025 SHALL hold out, sat, ovf between dumps; out_en=0 on non-dump cycles.
REQ-026 SHALL, with en low, freeze accumulator, window counter and FSM state, and hold out_en at 0.
REQ-027 SHALL apply a mode change only while in IDLE; the window counter clears on every mode change.
REQ-028 SHALL sample gain on the dump cycle only.

Reset
REQ-029 SHALL, on rst, set acc=0, window counter=0, FSM=IDLE, out=0, out_en=0, sat=0, ovf=0 at the next edge, overriding en.
REQ-030 SHALL, on rst mid-count, discard the partial count and emit no dump.

Structure
REQ-031 SHALL place FSM state encoding and the symmetric-limit function (from WIDTH) in a shared package, freq_err_pkg.
REQ-032 SHALL implement the saturating barrel shift as sub-module sat_shl (WIDTH, GAIN_W).

Verification (WIDTH=8, STEP=1, WIN=16)
REQ-033 SHALL cover: mode 0, gain=2, R-only x5 then R=V=1 -> 1 cycle later out_en=1, out=20, sat=0, ovf=0.
REQ-034 SHALL cover: mode 0, gain=2, V-only x3 then R=V=0 -> out=-12; a further R=V cycle emits no out_en.
REQ-035 SHALL cover: mode 0, gain=0, R-only x200 then R=V -> out=127, sat=1; FSM passed through CLIP.
REQ-036 SHALL cover: mode 0, gain=2, R-only x40 then R=V -> out=127, ovf=1, sat=0.
REQ-037 SHALL cover: mode 1, gain=2, a 16-cycle window with 6 R-only and 2 V-only cycles -> out_en on cycle 17, out=16; an idle window -> out=0.
REQ-038 SHALL cover: R-only x4, en low x3 with R-only, then R=V -> out=16 (gain=2); rst mid-count -> no out_en, out=0.
